// File: rtl/mem_wr_arbiter.sv
// rtl/mem_wr_arbiter.sv - RAM write-port arbiter: AXI path has priority, loader writes queue in a FIFO.
// Optional MEM_WR_ARB_FAIR_EN bounds loader wait to MAX_WAIT+1 cycles under continuous AXI traffic.
module mem_wr_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter int MAX_WAIT       = 15
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic                          axi_w_valid,
  output logic                          axi_w_ready,
  input  logic [ADDR_WIDTH-1:0]         axi_w_addr,
  input  logic [DATA_WIDTH-1:0]         axi_w_data,
  input  logic                          ld_w_valid,
  output logic                          ld_w_ready,
  input  logic [ADDR_WIDTH-1:0]         ld_w_addr,
  input  logic [DATA_WIDTH-1:0]         ld_w_data,
  output logic                          ram_w_en,
  output logic [RAM_ADDR_WIDTH-1:0]     ram_w_addr,
  output logic [DATA_WIDTH-1:0]         ram_w_data,
  output logic [$clog2(FIFO_DEPTH):0]   ld_fifo_level,
  output logic                          ld_busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [RAM_ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [LVL_W-1:0]          r_level;
  logic                      r_ram_en;
  logic [RAM_ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0]     r_ram_data;
  logic                      r_last_ld;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_force_ld;
  logic w_grant_axi;
  logic w_grant_ld;

  // Byte-lane bits and address bits above the RAM range are not used by the RAM.
  logic w_unused_addr;
  assign w_unused_addr = ^{axi_w_addr[1:0], axi_w_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2],
                           ld_w_addr[1:0],  ld_w_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2]};

  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
  assign ld_w_ready  = ARESETn & ~w_full;
  assign w_push      = ld_w_valid & ld_w_ready;
  assign axi_w_ready = ARESETn & ~w_force_ld;
  assign w_grant_axi = axi_w_valid & axi_w_ready;
  assign w_grant_ld  = ~w_grant_axi & ~w_empty;

`ifdef MEM_WR_ARB_FAIR_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] r_wait;

  assign w_force_ld = (r_wait == WAIT_W'(MAX_WAIT)) & ~w_empty;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_wait <= '0;
    end else if (w_grant_ld || w_empty) begin
      r_wait <= '0;
    end else if (w_grant_axi) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end
`else
  localparam int UNUSED_MAX_WAIT = MAX_WAIT;
  assign w_force_ld = 1'b0;
`endif

  // FIFO storage carries no reset; only pointers and level define validity.
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= ld_w_addr[RAM_ADDR_WIDTH+1:2];
      r_fifo_data[r_wr_ptr] <= ld_w_data;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_ram_en   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_last_ld  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_grant_ld) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level   <= r_level + LVL_W'(w_push) - LVL_W'(w_grant_ld);
      r_ram_en  <= w_grant_axi | w_grant_ld;
      r_last_ld <= w_grant_ld;
      if (w_grant_axi) begin
        r_ram_addr <= axi_w_addr[RAM_ADDR_WIDTH+1:2];
        r_ram_data <= axi_w_data;
      end else if (w_grant_ld) begin
        r_ram_addr <= r_fifo_addr[r_rd_ptr];
        r_ram_data <= r_fifo_data[r_rd_ptr];
      end
    end
  end

  assign ram_w_en      = r_ram_en;
  assign ram_w_addr    = r_ram_addr;
  assign ram_w_data    = r_ram_data;
  assign ld_fifo_level = r_level;
  assign ld_busy       = (r_level != '0) | (r_ram_en & r_last_ld);
endmodule

// File: tb/tb_mem_wr_arbiter.sv
// tb/tb_mem_wr_arbiter.sv - Directed table-driven bench for mem_wr_arbiter plus multi-cycle corner sequences.
module tb_mem_wr_arbiter;
  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        axi_w_valid;
  logic        axi_w_ready;
  logic [31:0] axi_w_addr;
  logic [31:0] axi_w_data;
  logic        ld_w_valid;
  logic        ld_w_ready;
  logic [31:0] ld_w_addr;
  logic [31:0] ld_w_data;
  logic        ram_w_en;
  logic [15:0] ram_w_addr;
  logic [31:0] ram_w_data;
  logic [3:0]  ld_fifo_level;
  logic        ld_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  mem_wr_arbiter dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .axi_w_valid   (axi_w_valid),
    .axi_w_ready   (axi_w_ready),
    .axi_w_addr    (axi_w_addr),
    .axi_w_data    (axi_w_data),
    .ld_w_valid    (ld_w_valid),
    .ld_w_ready    (ld_w_ready),
    .ld_w_addr     (ld_w_addr),
    .ld_w_data     (ld_w_data),
    .ram_w_en      (ram_w_en),
    .ram_w_addr    (ram_w_addr),
    .ram_w_data    (ram_w_data),
    .ld_fifo_level (ld_fifo_level),
    .ld_busy       (ld_busy)
  );

  typedef struct {
    logic        av;
    logic [31:0] aa;
    logic [31:0] ad;
    logic        lv;
    logic [31:0] la;
    logic [31:0] ld;
    logic        e_ar;
    logic        e_lr;
    logic        e_en;
    logic [15:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_lvl;
    logic        e_busy;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [31:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [31:0] la, input logic [31:0] ld);
    axi_w_valid = av;
    axi_w_addr  = aa;
    axi_w_data  = ad;
    ld_w_valid  = lv;
    ld_w_addr   = la;
    ld_w_data   = ld;
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    //           av    aa            ad            lv    la        ld        ar    lr    en    addr      data          lvl   busy
    vecs[0]  = '{1'b1, 32'h104,      32'hDEADBEEF, 1'b0, 32'h0,    32'h0,    1'b1, 1'b1, 1'b1, 16'h0041, 32'hDEADBEEF, 4'd0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0,    32'h0,    1'b1, 1'b1, 1'b0, 16'h0041, 32'hDEADBEEF, 4'd0, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,       32'h1,        1'b1, 32'h10,   32'h2,    1'b1, 1'b1, 1'b1, 16'h0004, 32'h1,        4'd1, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0,    32'h0,    1'b1, 1'b1, 1'b1, 16'h0004, 32'h2,        4'd0, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0,    32'h0,    1'b1, 1'b1, 1'b0, 16'h0004, 32'h2,        4'd0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h20,   32'hA5,   1'b1, 1'b1, 1'b0, 16'h0004, 32'h2,        4'd1, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0,    32'h0,    1'b1, 1'b1, 1'b1, 16'h0008, 32'hA5,       4'd0, 1'b1};
    vecs[7]  = '{1'b1, 32'h30,       32'h77,       1'b1, 32'h24,   32'hB6,   1'b1, 1'b1, 1'b1, 16'h000C, 32'h77,       4'd1, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h28,   32'hC7,   1'b1, 1'b1, 1'b1, 16'h0009, 32'hB6,       4'd1, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0,    32'h0,    1'b1, 1'b1, 1'b1, 16'h000A, 32'hC7,       4'd0, 1'b1};
    vecs[10] = '{1'b0, 32'h0,        32'h0,        1'b0, 32'h0,    32'h0,    1'b1, 1'b1, 1'b0, 16'h000A, 32'hC7,       4'd0, 1'b0};
    vecs[11] = '{1'b1, 32'h107,      32'h11,       1'b0, 32'h0,    32'h0,    1'b1, 1'b1, 1'b1, 16'h0041, 32'h11,       4'd0, 1'b0};
    vecs[12] = '{1'b1, 32'hFFFF000B, 32'h22,       1'b0, 32'h0,    32'h0,    1'b1, 1'b1, 1'b1, 16'hC002, 32'h22,       4'd0, 1'b0};

    ARESETn = 1'b0;
    drive(1'b1, 32'h40, 32'h55, 1'b1, 32'h80, 32'h66);
    repeat (3) step();
    check("rst_axi_ready", 64'(axi_w_ready), 64'd0);
    check("rst_ld_ready", 64'(ld_w_ready), 64'd0);
    check("rst_ram_en", 64'(ram_w_en), 64'd0);
    check("rst_level", 64'(ld_fifo_level), 64'd0);
    check("rst_busy", 64'(ld_busy), 64'd0);

    ARESETn = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld);
      #1;
      check($sformatf("v%0d_axi_ready", i), 64'(axi_w_ready), 64'(vecs[i].e_ar));
      check($sformatf("v%0d_ld_ready", i), 64'(ld_w_ready), 64'(vecs[i].e_lr));
      step();
      check($sformatf("v%0d_ram_en", i), 64'(ram_w_en), 64'(vecs[i].e_en));
      check($sformatf("v%0d_ram_addr", i), 64'(ram_w_addr), 64'(vecs[i].e_addr));
      check($sformatf("v%0d_ram_data", i), 64'(ram_w_data), 64'(vecs[i].e_data));
      check($sformatf("v%0d_level", i), 64'(ld_fifo_level), 64'(vecs[i].e_lvl));
      check($sformatf("v%0d_busy", i), 64'(ld_busy), 64'(vecs[i].e_busy));
    end

    // Fill the FIFO while AXI owns the port every cycle.
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 32'h5000 + 32'(k), 1'b1, 32'h200 + 32'(4 * k), 32'h1000 + 32'(k));
      #1;
      check($sformatf("full%0d_ld_ready", k), 64'(ld_w_ready), 64'(k < 8));
      check($sformatf("full%0d_axi_ready", k), 64'(axi_w_ready), 64'd1);
      step();
      check($sformatf("full%0d_ram_addr", k), 64'(ram_w_addr), 64'(16'h0040 + 16'(k)));
      check($sformatf("full%0d_ram_data", k), 64'(ram_w_data), 64'(32'h5000 + 32'(k)));
      check($sformatf("full%0d_level", k), 64'(ld_fifo_level), 64'((k < 8) ? k + 1 : 8));
    end
    // A pop in the same cycle must not open a full FIFO to a push.
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h3FC, 32'hBAD);
    #1;
    check("drain0_ld_ready", 64'(ld_w_ready), 64'd0);
    step();
    check("drain0_ram_en", 64'(ram_w_en), 64'd1);
    check("drain0_ram_addr", 64'(ram_w_addr), 64'h80);
    check("drain0_ram_data", 64'(ram_w_data), 64'h1000);
    check("drain0_level", 64'(ld_fifo_level), 64'd7);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int j = 1; j < 8; j++) begin
      step();
      check($sformatf("drain%0d_ram_en", j), 64'(ram_w_en), 64'd1);
      check($sformatf("drain%0d_ram_addr", j), 64'(ram_w_addr), 64'(16'h0080 + 16'(j)));
      check($sformatf("drain%0d_ram_data", j), 64'(ram_w_data), 64'(32'h1000 + 32'(j)));
      check($sformatf("drain%0d_level", j), 64'(ld_fifo_level), 64'(7 - j));
    end
    step();
    check("drained_ram_en", 64'(ram_w_en), 64'd0);
    check("drained_level", 64'(ld_fifo_level), 64'd0);
    check("drained_busy", 64'(ld_busy), 64'd0);

    // Reset with five loader entries pending.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h40, 32'h9, 1'b1, 32'h300 + 32'(4 * k), 32'h2000 + 32'(k));
      step();
    end
    check("mid_level", 64'(ld_fifo_level), 64'd5);
    ARESETn = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    #1;
    check("mid_rst_axi_ready", 64'(axi_w_ready), 64'd0);
    check("mid_rst_ld_ready", 64'(ld_w_ready), 64'd0);
    step();
    check("mid_rst_level", 64'(ld_fifo_level), 64'd0);
    check("mid_rst_ram_en", 64'(ram_w_en), 64'd0);
    check("mid_rst_busy", 64'(ld_busy), 64'd0);
    ARESETn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("post_rst%0d_ram_en", c), 64'(ram_w_en), 64'd0);
      check($sformatf("post_rst%0d_level", c), 64'(ld_fifo_level), 64'd0);
    end

`ifdef MEM_WR_ARB_FAIR_EN
    // One loader entry queued behind continuous AXI traffic.
    for (int t = 0; t < 30; t++) begin
      drive(1'b1, 32'h400 + 32'(4 * t), 32'h7000 + 32'(t), (t == 0), 32'h500, 32'hFA1);
      #1;
      check($sformatf("fair%0d_axi_ready", t), 64'(axi_w_ready), 64'(t != 16));
      step();
      if (t == 16) begin
        check("fair_ld_addr", 64'(ram_w_addr), 64'h140);
        check("fair_ld_data", 64'(ram_w_data), 64'hFA1);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
